// File: rtl/capture_ctrl.sv
// Trigger/capture sequencer: fills a circular sample RAM around a level/edge
// trigger and reports where the finished record starts.
//
// state  | meaning
// S_IDLE | no capture, waiting for arm
// S_PRE  | filling the pre-trigger window, trigger not evaluated
// S_WAIT | writing circularly, evaluating edge / auto trigger
// S_POST | filling the post-trigger window
// S_DONE | record complete and held until next arm
module capture_ctrl #(
  parameter int DEPTH_LOG2   = 9,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [11:0]           sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [11:0]           trig_level,
  input  logic                  trig_edge,
  input  logic                  trig_auto,
  input  logic [DEPTH_LOG2-1:0] pretrig,
  output logic                  wr_en,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic [DEPTH_LOG2-1:0] start_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  trig_forced
);

  localparam int AW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2-1:0] ONE       = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] MAX_IDX   = '1;
  localparam logic [AW-1:0]         AUTO_LAST = AW'(AUTO_TIMEOUT - 1);
  localparam logic [AW-1:0]         AUTO_ONE  = AW'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;
  state_t state, state_nxt;

  logic [11:0]           level_l;
  logic                  edge_l;
  logic                  auto_l;
  logic [DEPTH_LOG2-1:0] pretrig_l;
  logic [DEPTH_LOG2-1:0] pre_cnt;
  logic [DEPTH_LOG2-1:0] post_cnt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [AW-1:0]         auto_cnt;
  logic [11:0]           prev;
  logic                  prev_valid;

  logic                  arm_ok;
  logic                  cap;
  logic                  cross_hit;
  logic                  auto_hit;
  logic                  trig_hit;
  logic                  pre_last;
  logic                  post_last;
  logic [DEPTH_LOG2-1:0] post_val;

  // pretrig is only DEPTH_LOG2 bits wide, so it can never exceed DEPTH-1.
  assign post_val  = MAX_IDX - pretrig_l;
  assign arm_ok    = arm && !abort && (state == S_IDLE || state == S_DONE);
  assign cap       = sample_valid && !abort &&
                     (state == S_PRE || state == S_WAIT || state == S_POST);
  assign cross_hit = prev_valid &&
                     (edge_l ? (prev > level_l && sample_in <= level_l)
                             : (prev < level_l && sample_in >= level_l));
  assign auto_hit  = auto_l && (auto_cnt == AUTO_LAST);
  assign trig_hit  = cap && (state == S_WAIT) && (cross_hit || auto_hit);
  assign pre_last  = cap && (state == S_PRE) && ((pre_cnt + ONE) == pretrig_l);
  assign post_last = cap && (state == S_POST) && (post_cnt == ONE);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm) state_nxt = (pretrig == '0) ? S_WAIT : S_PRE;
        S_PRE:          if (pre_last) state_nxt = S_WAIT;
        S_WAIT:         if (trig_hit) state_nxt = (post_val == '0) ? S_DONE : S_POST;
        S_POST:         if (post_last) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_PRE, S_WAIT, S_POST: busy = 1'b1;
      S_DONE:                done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      trig_addr   <= '0;
      start_addr  <= '0;
      trig_forced <= 1'b0;
      level_l     <= '0;
      edge_l      <= 1'b0;
      auto_l      <= 1'b0;
      pretrig_l   <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      wr_ptr      <= '0;
      auto_cnt    <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
    end else begin
      wr_en <= cap;
      if (cap) begin
        wr_data    <= sample_in;
        wr_addr    <= wr_ptr;
        wr_ptr     <= wr_ptr + ONE;
        prev       <= sample_in;
        prev_valid <= 1'b1;
      end
      if (cap && state == S_PRE) pre_cnt <= pre_cnt + ONE;
      if (cap && state == S_WAIT && auto_l) auto_cnt <= auto_cnt + AUTO_ONE;
      if (cap && state == S_POST) post_cnt <= post_cnt - ONE;
      // A real crossing takes precedence over a coincident timeout.
      if (trig_hit) begin
        trig_addr   <= wr_ptr;
        start_addr  <= wr_ptr - pretrig_l;
        trig_forced <= auto_hit && !cross_hit;
        post_cnt    <= post_val;
      end
      if (arm_ok) begin
        level_l     <= trig_level;
        edge_l      <= trig_edge;
        auto_l      <= trig_auto;
        pretrig_l   <= pretrig;
        wr_addr     <= '0;
        wr_ptr      <= '0;
        pre_cnt     <= '0;
        auto_cnt    <= '0;
        prev_valid  <= 1'b0;
        trig_forced <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: a per-sample record model checked every cycle, plus
// literal expectations for each directed scenario.
module tb_capture_ctrl;
  localparam int DEPTH = 16;
  localparam int AUTO  = 32;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [11:0] sample_in;
  logic        sample_valid, arm, abort;
  logic [11:0] trig_level;
  logic        trig_edge, trig_auto;
  logic [3:0]  pretrig;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  trig_addr, start_addr;
  logic        busy, done, trig_forced;

  capture_ctrl #(.DEPTH_LOG2(4), .AUTO_TIMEOUT(AUTO)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .sample_in(sample_in),
    .sample_valid(sample_valid), .arm(arm), .abort(abort),
    .trig_level(trig_level), .trig_edge(trig_edge), .trig_auto(trig_auto),
    .pretrig(pretrig), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .trig_addr(trig_addr), .start_addr(start_addr), .busy(busy), .done(done),
    .trig_forced(trig_forced)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  int nwr     = 0;
  bit chk_en  = 0;

  // Record model: n counts samples written since arm; the record phase
  // follows from n, the trigger index and the latched window sizes.
  bit m_active, m_done, m_trig, m_have_prev, m_forced, m_edge, m_auto;
  int m_n, m_trig_idx, m_pre, m_post, m_lvl, m_prev;
  bit exp_wr_en;
  int exp_wr_addr, exp_wr_data, exp_trig_addr, exp_start;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_trig = 0; m_have_prev = 0; m_forced = 0;
    m_n = 0; m_trig_idx = 0; m_pre = 0; m_post = 0; m_prev = 0;
    exp_wr_en = 0; exp_wr_addr = 0; exp_wr_data = 0;
    exp_trig_addr = 0; exp_start = 0;
  endtask

  task automatic model_step(input bit a, input bit ab, input bit sv, input int s_raw);
    int s;
    bit hit_x, hit_a;
    s = s_raw & 'hFFF;
    exp_wr_en = 0;
    if (ab) begin
      m_active = 0;
      m_done   = 0;
    end else if (m_active) begin
      if (sv) begin
        exp_wr_en   = 1;
        exp_wr_addr = m_n % DEPTH;
        exp_wr_data = s;
        if (!m_trig && m_n >= m_pre) begin
          hit_x = m_have_prev && (m_edge ? (m_prev > m_lvl && s <= m_lvl)
                                         : (m_prev < m_lvl && s >= m_lvl));
          hit_a = m_auto && (m_n - m_pre + 1 == AUTO);
          if (hit_x || hit_a) begin
            m_trig        = 1;
            m_trig_idx    = m_n;
            exp_trig_addr = m_n % DEPTH;
            exp_start     = (m_n - m_pre) % DEPTH;
            m_forced      = !hit_x;
          end
        end
        m_have_prev = 1;
        m_prev      = s;
        m_n++;
        if (m_trig && (m_n - 1 - m_trig_idx == m_post)) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (a) begin
      m_lvl = int'(trig_level); m_edge = trig_edge; m_auto = trig_auto;
      m_pre = (int'(pretrig) > DEPTH - 1) ? DEPTH - 1 : int'(pretrig);
      m_post = DEPTH - 1 - m_pre;
      m_n = 0; m_have_prev = 0; m_trig = 0; m_forced = 0;
      m_active = 1; m_done = 0;
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("wr_en", wr_en, exp_wr_en);
      if (exp_wr_en) begin
        chk("wr_addr", wr_addr, exp_wr_addr);
        chk("wr_data", wr_data, exp_wr_data);
      end
      if (m_done) begin
        chk("trig_addr", trig_addr, exp_trig_addr);
        chk("start_addr", start_addr, exp_start);
        chk("trig_forced", trig_forced, m_forced);
      end
      if (wr_en) nwr++;
    end
  end

  task automatic cyc(input bit a, input bit ab, input bit sv, input int s);
    arm = a; abort = ab; sample_valid = sv; sample_in = 12'(s);
    @(posedge CLOCK_50);
    model_step(a, ab, sv, s);
    #1;
  endtask

  task automatic feed(input int s);
    cyc(0, 0, 1, s);
  endtask

  task automatic set_cfg(input int lvl, input bit e, input bit au, input int p);
    trig_level = 12'(lvl); trig_edge = e; trig_auto = au; pretrig = 4'(p);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_trig_addr"}, trig_addr, 0);
    chk({tag, "_start_addr"}, start_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_trig_forced"}, trig_forced, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; arm = 0; abort = 0; sample_valid = 0; sample_in = 0;
    set_cfg(0, 0, 0, 0);
    model_reset();
    #12;
    chk_all_zero("reset");
    @(posedge CLOCK_50); #1;
    reset = 1;
    chk_en = 1;

    // arm and abort together: abort wins
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("arm_abort_busy", busy, 0);

    // rising edge, pretrig 4
    set_cfg('h800, 0, 0, 4);
    nwr = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) feed((k * 256) & 'hFFF);
    cyc(0, 0, 0, 0);
    chk("rise_trig_addr", trig_addr, 8);
    chk("rise_start_addr", start_addr, 4);
    chk("rise_writes", nwr, 20);
    chk("rise_done", done, 1);
    chk("rise_forced", trig_forced, 0);
    feed('h300);
    feed('h300);

    // falling edge, pretrig 2; arm cycle carries a sample that is not captured
    set_cfg('h400, 1, 0, 2);
    nwr = 0;
    cyc(1, 0, 1, 'hFFF);
    feed('h800); cyc(0, 0, 0, 0);
    feed('h600); feed('h500); cyc(0, 0, 0, 0);
    feed('h400);
    for (int k = 0; k < 13; k++) feed((k + 2) * 16);
    cyc(0, 0, 0, 0);
    chk("fall_trig_addr", trig_addr, 3);
    chk("fall_start_addr", start_addr, 1);
    chk("fall_writes", nwr, 17);
    chk("fall_done", done, 1);

    // pretrig 0: first sample has no predecessor and must not trigger
    set_cfg('h800, 0, 0, 0);
    nwr = 0;
    cyc(1, 0, 0, 0);
    feed('h900); feed('h100); feed('h900);
    for (int k = 0; k < 15; k++) feed('h050);
    cyc(0, 0, 0, 0);
    chk("p0_trig_addr", trig_addr, 2);
    chk("p0_start_addr", start_addr, 2);
    chk("p0_writes", nwr, 18);
    chk("p0_done", done, 1);

    // pretrig at maximum: done coincides with the trigger write
    set_cfg('h800, 0, 0, 15);
    nwr = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) feed('h000);
    feed('h900);
    chk("pmax_done_at_trig", {30'd0, done, wr_en}, 3);
    cyc(0, 0, 0, 0);
    chk("pmax_trig_addr", trig_addr, 0);
    chk("pmax_start_addr", start_addr, 1);
    chk("pmax_writes", nwr, 17);

    // auto trigger on the 32nd waiting sample
    set_cfg('h800, 0, 1, 0);
    nwr = 0;
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 47; k++) feed('h100);
    cyc(0, 0, 0, 0);
    chk("auto_trig_addr", trig_addr, 15);
    chk("auto_start_addr", start_addr, 15);
    chk("auto_forced", trig_forced, 1);
    chk("auto_done", done, 1);
    chk("auto_writes", nwr, 47);

    // arm during POST is ignored
    set_cfg('h800, 0, 0, 1);
    nwr = 0;
    cyc(1, 0, 0, 0);
    feed('h000); feed('h000); feed('h900);
    for (int k = 0; k < 5; k++) feed('h222);
    cyc(1, 0, 1, 'h111);
    chk("post_arm_busy", busy, 1);
    for (int k = 0; k < 8; k++) feed('h333);
    cyc(0, 0, 0, 0);
    chk("post_arm_writes", nwr, 17);
    chk("post_arm_done", done, 1);
    chk("post_arm_trig_addr", trig_addr, 2);

    // abort during POST
    cyc(1, 0, 0, 0);
    feed('h000); feed('h000); feed('h900);
    for (int k = 0; k < 3; k++) feed('h444);
    cyc(0, 1, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    nwr = 0;
    for (int k = 0; k < 5; k++) feed('h555);
    cyc(0, 0, 0, 0);
    chk("abort_no_writes", nwr, 0);

    // no auto: waits indefinitely, then async reset mid-WAIT
    set_cfg('h800, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 1000; k++) feed('h100);
    chk("noauto_busy", busy, 1);
    chk("noauto_done", done, 0);
    chk("pre_reset_wr_en", wr_en, 1);
    chk_en = 0;
    reset  = 0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    #10;
    reset = 1;
    cyc(0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("after_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
